// File: rtl/ram_system_pkg.sv
// Shared widths and the seven-segment code table for the RAM demo system.
package ram_system_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 32;

    // Active-low segment images, bit order {g,f,e,d,c,b,a}, indexed by hex digit.
    localparam logic [6:0] SEG7_TABLE [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

endpackage

// File: rtl/ram_system_seg7.sv
// Combinational hex digit to active-low seven-segment decoder.
module seg7
    import ram_system_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG7_TABLE[digit_i];

endmodule

// File: rtl/ram_system.sv
// 32 x 4 register-array RAM with registered inputs, registered read data
// and seven-segment images of address, write data and read data.
module ram_system
    import ram_system_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [6:0]        addrHEX1,
    output logic [6:0]        addrHEX0,
    output logic [6:0]        wrHEX,
    output logic [6:0]        reHEX
);

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              we_q;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Next memory image: the registered write request lands one edge after capture.
    always_comb begin
        mem_d = mem_q;
        if (we_q) begin
            mem_d[addr_q] = data_q;
        end
    end

    // Input stage, memory update and read register; reset clears everything
    // and drops any write still pending in we_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            data_q <= '0;
            we_q   <= 1'b0;
            rd_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            addr_q <= addr;
            data_q <= wr_data;
            we_q   <= wr_en;
            rd_q   <= mem_q[addr_q];  // old contents on a same-edge write
            mem_q  <= mem_d;
        end
    end

    seg7 u_seg_addr1 (.digit_i({3'b000, addr_q[4]}), .seg_o(addrHEX1));
    seg7 u_seg_addr0 (.digit_i(addr_q[3:0]),         .seg_o(addrHEX0));
    seg7 u_seg_wr    (.digit_i(data_q),              .seg_o(wrHEX));
    seg7 u_seg_rd    (.digit_i(rd_q),                .seg_o(reHEX));

endmodule

// File: tb/tb_ram_system.sv
// Scoreboard bench for ram_system: the driver pushes hand-computed displays
// expected after each edge, the monitor pops and compares 1 time unit after it.
module tb_ram_system;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [4:0] addr;
    logic [3:0] wr_data;
    logic [6:0] addrHEX1;
    logic [6:0] addrHEX0;
    logic [6:0] wrHEX;
    logic [6:0] reHEX;

    int n_tests;
    int n_fail;

    typedef struct {
        int         id;
        logic [6:0] h1;
        logic [6:0] h0;
        logic [6:0] wr;
        logic [6:0] re;
    } exp_t;

    exp_t sb_q[$];
    int   vec_id;

    logic [6:0] seg [16];

    ram_system dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .addr     (addr),
        .wr_data  (wr_data),
        .addrHEX1 (addrHEX1),
        .addrHEX0 (addrHEX0),
        .wrHEX    (wrHEX),
        .reHEX    (reHEX)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one vector at the falling edge and queue what the displays
    // must show after the following rising edge.
    task automatic apply(input logic r, input logic we, input logic [4:0] a,
                         input logic [3:0] d, input logic [6:0] eh1,
                         input logic [6:0] eh0, input logic [6:0] ewr,
                         input logic [6:0] ere);
        exp_t e;
        @(negedge clk);
        reset   = r;
        wr_en   = we;
        addr    = a;
        wr_data = d;
        e.id = vec_id;
        e.h1 = eh1;
        e.h0 = eh0;
        e.wr = ewr;
        e.re = ere;
        sb_q.push_back(e);
        vec_id++;
    endtask

    // Monitor: compare the oldest expectation against the settled outputs.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_tests += 4;
            if (addrHEX1 !== e.h1) begin
                n_fail++;
                $display("FAIL v%0d addrHEX1 got %b exp %b", e.id, addrHEX1, e.h1);
            end
            if (addrHEX0 !== e.h0) begin
                n_fail++;
                $display("FAIL v%0d addrHEX0 got %b exp %b", e.id, addrHEX0, e.h0);
            end
            if (wrHEX !== e.wr) begin
                n_fail++;
                $display("FAIL v%0d wrHEX got %b exp %b", e.id, wrHEX, e.wr);
            end
            if (reHEX !== e.re) begin
                n_fail++;
                $display("FAIL v%0d reHEX got %b exp %b", e.id, reHEX, e.re);
            end
        end
    end

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S5 = 7'b0010010, S7 = 7'b1111000,
                           S9 = 7'b0010000, SA = 7'b0001000, SF = 7'b0001110;

    initial begin
        int guard;
        n_tests = 0;
        n_fail  = 0;
        vec_id  = 0;
        seg = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        reset = 1'b1; wr_en = 1'b0; addr = '0; wr_data = '0;

        //     rst we  addr   data   h1  h0  wr  re
        apply(1, 0, 5'd0,  4'd0,  S0, S0, S0, S0);   // reset state
        apply(0, 0, 5'd0,  4'd0,  S0, S0, S0, S0);
        apply(0, 0, 5'd0,  4'd0,  S0, S0, S0, S0);
        // write 2 to address 1, held three edges
        apply(0, 1, 5'd1,  4'd2,  S0, S1, S2, S0);
        apply(0, 1, 5'd1,  4'd2,  S0, S1, S2, S0);
        apply(0, 1, 5'd1,  4'd2,  S0, S1, S2, S2);
        // write 9 to address 10 (bit 4 clear, so addrHEX1 shows 0)
        apply(0, 1, 5'd10, 4'd9,  S0, SA, S9, S2);
        apply(0, 1, 5'd10, 4'd9,  S0, SA, S9, S0);
        apply(0, 1, 5'd10, 4'd9,  S0, SA, S9, S9);
        // read back addresses 1 and 10
        apply(0, 0, 5'd1,  4'd0,  S0, S1, S0, S9);
        apply(0, 0, 5'd1,  4'd0,  S0, S1, S0, S2);
        apply(0, 0, 5'd10, 4'd0,  S0, SA, S0, S2);
        apply(0, 0, 5'd10, 4'd0,  S0, SA, S0, S9);
        // write 15 to address 31, then reset with a write still requested
        apply(0, 1, 5'd31, 4'd15, S1, SF, SF, S9);
        apply(0, 1, 5'd31, 4'd15, S1, SF, SF, S0);
        apply(0, 1, 5'd31, 4'd15, S1, SF, SF, SF);
        apply(1, 1, 5'd31, 4'd15, S0, S0, S0, S0);
        apply(0, 0, 5'd31, 4'd0,  S1, SF, S0, S0);
        apply(0, 0, 5'd31, 4'd0,  S1, SF, S0, S0);
        // 5 then 7 to address 3, last write wins
        apply(0, 1, 5'd3,  4'd5,  S0, S3, S5, S0);
        apply(0, 1, 5'd3,  4'd7,  S0, S3, S7, S0);
        apply(0, 0, 5'd3,  4'd0,  S0, S3, S0, S5);
        apply(0, 0, 5'd3,  4'd0,  S0, S3, S0, S7);
        // reset also cleared address 1
        apply(0, 0, 5'd1,  4'd0,  S0, S1, S0, S7);
        apply(0, 0, 5'd1,  4'd0,  S0, S1, S0, S0);
        // back-to-back writes of i to address 16+i; each read sees old data (0)
        for (int i = 0; i < 16; i++) begin
            apply(0, 1, 5'(16 + i), 4'(i), S1, seg[i], seg[i], S0);
        end
        // read them back; each edge shows the previous address's word
        for (int i = 0; i < 16; i++) begin
            apply(0, 0, 5'(16 + i), 4'd0, S1, seg[i], S0,
                  (i == 0) ? S0 : seg[i-1]);
        end
        apply(0, 0, 5'd16, 4'd0, S1, S0, S0, SF);

        guard = 0;
        while (sb_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (sb_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain %0d expectations left, exp 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
